// File: rtl/stm_reg_sequencer_if.sv
// Store-multiple sequencer bus: command inputs, register-file read port and memory write beat.
interface stm_reg_sequencer_if;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [1:0]  mode;
  logic [3:0]  ra;
  logic [31:0] rd;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [31:0] wb_value;

  modport master (
    input  start, reg_list, base_addr, mode, rd, mem_ready,
    output ra, mem_we, mem_addr, mem_wdata, busy, done, wb_value
  );

  modport slave (
    output start, reg_list, base_addr, mode, rd, mem_ready,
    input  ra, mem_we, mem_addr, mem_wdata, busy, done, wb_value
  );
endinterface

// File: rtl/stm_reg_sequencer.sv
// Store-multiple sequencer: writes the listed registers to memory in ascending order, one beat per accept.
// First beat two cycles after start; beats stall while mem_ready is low; done pulses one cycle after the last beat.
module stm_reg_sequencer (
  input  logic                clk,
  input  logic                reset_n,
  stm_reg_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] list_q;
  logic [31:0] base_q;
  logic [1:0]  mode_q;
  logic [31:0] addr_q;
  logic [31:0] wb_q;
  logic [3:0]  ra_q;

  logic [4:0]  n_regs;
  logic [31:0] span;
  logic [31:0] first_addr;
  logic [31:0] wb_next;
  logic [15:0] list_rest;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // Block spans 4n bytes; decrementing modes place the lowest register at the bottom of that span.
  always_comb begin
    n_regs     = popcount16(list_q);
    span       = {25'd0, n_regs, 2'b00};
    wb_next    = mode_q[1] ? (base_q - span) : (base_q + span);
    first_addr = base_q;
    case (mode_q)
      2'b00:   first_addr = base_q;
      2'b01:   first_addr = base_q + 32'd4;
      2'b10:   first_addr = base_q - span + 32'd4;
      default: first_addr = base_q - span;
    endcase
    list_rest  = list_q & (list_q - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      list_q <= '0;
      base_q <= '0;
      mode_q <= '0;
      addr_q <= '0;
      wb_q   <= '0;
      ra_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            list_q <= bus.reg_list;
            base_q <= bus.base_addr;
            mode_q <= bus.mode;
            state  <= SETUP;
          end
        end
        SETUP: begin
          wb_q   <= wb_next;
          addr_q <= first_addr;
          if (n_regs == 5'd0) begin
            state <= DONE;
          end else begin
            ra_q  <= lowest_idx(list_q);
            state <= XFER;
          end
        end
        XFER: begin
          if (bus.mem_ready) begin
            list_q <= list_rest;
            addr_q <= addr_q + 32'd4;
            if (list_rest == 16'd0) begin
              ra_q  <= '0;
              state <= DONE;
            end else begin
              ra_q  <= lowest_idx(list_rest);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ra        = ra_q;
  assign bus.mem_we    = (state == XFER);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = (state == XFER) ? bus.rd : 32'd0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.wb_value  = wb_q;

endmodule

// File: tb/tb_stm_reg_sequencer.sv
// Scoreboard bench for stm_reg_sequencer: expected beats and completions are queued at start, a monitor pops and compares.
module tb_stm_reg_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  stm_reg_sequencer_if bus();

  stm_reg_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Register file; entry 15 stands for the PC.
  logic [31:0] regfile [16];
  assign bus.rd = regfile[bus.ra];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ra;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] wb;
    int          cyc;
  } fin_t;

  beat_t beat_q[$];
  fin_t  fin_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int stall_req = 0;
  int txn_id = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mem_ready generator: 0 tied high, 1 random, 2 stall first beat stall_req cycles, other held low.
  initial begin
    int stall_left;
    int seen_id;
    stall_left    = 0;
    seen_id       = 0;
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (txn_id != seen_id) begin
        seen_id    = txn_id;
        stall_left = stall_req;
      end
      case (ready_mode)
        0: bus.mem_ready = 1'b1;
        1: bus.mem_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.mem_we && stall_left > 0) begin
            bus.mem_ready = 1'b0;
            stall_left--;
          end else begin
            bus.mem_ready = 1'b1;
          end
        end
        default: bus.mem_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  beat_t       mb;
  fin_t        mf;
  logic        held_vld = 1'b0;
  logic [31:0] held_addr, held_data;
  logic [3:0]  held_ra;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_we && held_vld) begin
        check("stall_addr_stable", bus.mem_addr, held_addr);
        check("stall_wdata_stable", bus.mem_wdata, held_data);
        check("stall_ra_stable", {28'd0, bus.ra}, {28'd0, held_ra});
      end
      if (bus.mem_we && bus.mem_ready) begin
        if (beat_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr %h data %h expected no beat (cycle %0d)",
                   bus.mem_addr, bus.mem_wdata, cyc);
        end else begin
          mb = beat_q.pop_front();
          check("beat_addr", bus.mem_addr, mb.addr);
          check("beat_wdata", bus.mem_wdata, mb.data);
          check("beat_ra", {28'd0, bus.ra}, {28'd0, mb.ra});
          if (mb.cyc >= 0) check("beat_cycle", cyc, mb.cyc);
        end
      end
      held_vld  = bus.mem_we && !bus.mem_ready;
      held_addr = bus.mem_addr;
      held_data = bus.mem_wdata;
      held_ra   = bus.ra;
      if (!bus.mem_we) check("ra_zero_outside_xfer", {28'd0, bus.ra}, 32'd0);
      if (bus.done) begin
        if (fin_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done wb %h expected no done (cycle %0d)", bus.wb_value, cyc);
        end else begin
          mf = fin_q.pop_front();
          check("wb_value", bus.wb_value, mf.wb);
          if (mf.cyc >= 0) check("done_cycle", cyc, mf.cyc);
        end
      end
    end
  end

  // Reference model: registers land in ascending index order at ascending addresses;
  // increment modes grow upward from base, decrement modes end at base (DA) or base-4 (DB).
  task automatic push_model(input logic [15:0] list, input logic [31:0] base, input logic [1:0] mode,
                            input int c, input int s, input int rmode);
    int          n;
    int          k;
    beat_t       b;
    fin_t        f;
    n = $countones(list);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        if (!mode[1]) b.addr = base + (mode[0] ? 32'd4 : 32'd0) + 32'(4 * k);
        else          b.addr = base - (mode[0] ? 32'd4 : 32'd0) - 32'(4 * (n - 1 - k));
        b.data = regfile[i];
        b.ra   = 4'(i);
        b.cyc  = (rmode == 1) ? -1 : c + 2 + k + s;
        beat_q.push_back(b);
        k++;
      end
    end
    f.wb  = mode[1] ? (base - 32'(4 * n)) : (base + 32'(4 * n));
    f.cyc = (rmode == 1) ? -1 : c + 2 + n + ((n > 0) ? s : 0);
    fin_q.push_back(f);
  endtask

  task automatic reset_state_check();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_ra", {28'd0, bus.ra}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_wb_value", bus.wb_value, 32'd0);
  endtask

  task automatic run_txn(input logic [15:0] list, input logic [31:0] base, input logic [1:0] mode,
                         input int rmode, input bit noise);
    int c;
    int s;
    int guard;
    for (int i = 0; i < 16; i++) regfile[i] = $urandom;
    s = (rmode == 2) ? 3 : 0;
    @(posedge clk);
    #1;
    stall_req     = s;
    txn_id        = txn_id + 1;
    ready_mode    = rmode;
    bus.start     = 1'b1;
    bus.reg_list  = list;
    bus.base_addr = base;
    bus.mode      = mode;
    c = cyc;
    push_model(list, base, mode, c, s, rmode);
    @(posedge clk);
    #1;
    check("busy_in_setup", {31'd0, bus.busy}, 32'd1);
    guard = 0;
    while (bus.busy && guard < 400) begin
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        bus.reg_list  = 16'($urandom);
        bus.base_addr = $urandom;
        bus.mode      = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      #1;
      guard++;
    end
    bus.start = 1'b0;
    if (guard >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL txn_timeout: got busy after %0d cycles expected idle", guard);
    end
    repeat (2) @(posedge clk);
    #1;
    check("beats_outstanding", beat_q.size(), 32'd0);
    check("done_outstanding", fin_q.size(), 32'd0);
    ready_mode = 0;
  endtask

  task automatic reset_midway();
    int c;
    for (int i = 0; i < 16; i++) regfile[i] = $urandom;
    @(posedge clk);
    #1;
    ready_mode    = 0;
    bus.start     = 1'b1;
    bus.reg_list  = 16'h1248;
    bus.base_addr = 32'h0000_0800;
    bus.mode      = 2'b00;
    c = cyc;
    push_model(16'h1248, 32'h0000_0800, 2'b00, c, 0, 0);
    @(posedge clk);
    #1;
    bus.reg_list = 16'hFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    // Second beat is on the bus now; reset it away with a start pulse alongside.
    reset_n    = 1'b0;
    ready_mode = 3;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    check("beats_left_at_reset", beat_q.size(), 32'd3);
    beat_q.delete();
    fin_q.delete();
    reset_state_check();
    reset_n    = 1'b1;
    bus.start  = 1'b0;
    ready_mode = 0;
    repeat (8) @(posedge clk);
    #1;
    check("idle_after_reset", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] list;
    logic [31:0] base;
    for (int i = 0; i < 16; i++) regfile[i] = $urandom | 32'h1;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.reg_list  = '0;
    bus.base_addr = '0;
    bus.mode      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_state_check();
    reset_n = 1'b1;
    mon_en  = 1'b1;

    run_txn(16'h000B, 32'h0000_0100, 2'b00, 0, 1'b0);
    run_txn(16'h8001, 32'h0000_0200, 2'b11, 0, 1'b0);
    run_txn(16'h0010, 32'h0000_0300, 2'b00, 2, 1'b0);
    run_txn(16'h0000, 32'h0000_0040, 2'b01, 0, 1'b0);
    run_txn(16'h0003, 32'hFFFF_FFFC, 2'b00, 0, 1'b0);
    run_txn(16'h0006, 32'h0000_1000, 2'b10, 0, 1'b0);
    run_txn(16'h00F0, 32'h0000_0020, 2'b01, 0, 1'b1);
    reset_midway();

    for (int t = 0; t < 40; t++) begin
      list = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      base = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) base = 32'hFFFF_FFF0;
      run_txn(list, base, 2'($urandom_range(0, 3)), $urandom_range(0, 1), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stm_reg_sequencer.md
STM_REG_SEQUENCER -- requirements
Module: stm_reg_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 start  in  1  one-cycle request to begin a store-multiple; honoured only in IDLE.
REQ-005 reg_list  in  16  bit i set means register Ri is stored; sampled with start.
REQ-006 base_addr  in  32  base register value (Rn); sampled with start.
REQ-007 mode  in  2  00=IA, 01=IB, 10=DA, 11=DB; sampled with start.
REQ-008 ra  out  4  register-file read address, driven to the a1 port.
REQ-009 rd  in  32  register-file read data for ra; combinational, same cycle; ra=15 returns the PC value.
REQ-010 mem_we  out  1  memory write valid.
REQ-011 mem_ready  in  1  memory accepts the beat on a cycle where mem_we and mem_ready are both high.
REQ-012 mem_addr  out  32  word-aligned byte address of the current beat.
REQ-013 mem_wdata  out  32  data of the current beat.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at completion.
REQ-016 wb_value  out  32  updated base value; valid while done is high.

Function
REQ-017 The FSM SHALL have four states, IDLE, SETUP, XFER and DONE, and SHALL encode them in 2 bits.
REQ-018 IDLE: on start=1, the block SHALL latch reg_list, base_addr and mode, and SHALL go to SETUP.
REQ-019 SETUP: the block SHALL compute n = popcount(reg_list) and the first address, IA=base, IB=base+4, DA=base-4n+4, DB=base-4n, all mod 2^32.
REQ-020 SETUP: the block SHALL compute wb_value: base+4n for IA/IB, base-4n for DA/DB.
REQ-021 SETUP: if n=0, the FSM SHALL go to DONE; otherwise it SHALL go to XFER.
REQ-022 XFER: ra SHALL equal the index of the lowest set bit of the remaining list, mem_wdata SHALL equal rd, mem_we SHALL be 1, and mem_addr SHALL equal the current address.
REQ-023 XFER: mem_addr, mem_wdata and ra SHALL be held stable while mem_ready=0.
REQ-024 XFER: on an accepted beat, the block SHALL clear the lowest set bit and add 4 to the address, wrapping 0xFFFFFFFC to 0x00000000.
REQ-025 XFER: when the last set bit is accepted, the FSM SHALL go to DONE.
REQ-026 Registers SHALL be issued in ascending index order in every mode, so the lowest register is always at the lowest address.
REQ-027 DONE: done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-028 start asserted in SETUP, XFER or DONE SHALL be ignored and SHALL NOT be queued.
REQ-029 Latency: with start at cycle 0 and mem_ready tied to 1, the first mem_we SHALL occur at cycle 2 and done at cycle 2+n; for n=0, done SHALL occur at cycle 2.
REQ-030 mem_we SHALL be 0 outside XFER; ra SHALL be 0 when not in XFER.
REQ-031 When reset_n is low in any state, including mid-transfer, the block SHALL return to IDLE on that edge with no further mem_we and no done.

Reset
REQ-032 After reset, the state SHALL be IDLE.
REQ-033 After reset, busy, done and mem_we SHALL be 0.
REQ-034 After reset, ra SHALL be 0, and mem_addr, mem_wdata and wb_value SHALL be 0x00000000.
REQ-035 After reset, the latched list, base and mode SHALL be cleared to 0.

Verification
REQ-036 IA, base=0x100, list=0x000B, mem_ready=1 -> beats (0x100,R0), (0x104,R1), (0x108,R3); done at cycle 5; wb_value=0x10C.
REQ-037 DB, base=0x200, list=0x8001 -> beats (0x1F8,R0), (0x1FC,PC via ra=15); wb_value=0x1F8.
REQ-038 IA, mem_ready low for 3 cycles on the first beat -> mem_addr, mem_wdata and ra are stable for all 4 cycles; the single beat is accepted once.
REQ-039 list=0x0000, IB, base=0x40 -> no mem_we; done at cycle 2; wb_value=0x40.
REQ-040 IA, base=0xFFFFFFFC, list=0x0003 -> beat addresses 0xFFFFFFFC, 0x00000000; wb_value=0x00000004.
REQ-041 reset_n low during the 2nd beat of a 4-register store, plus start pulses during busy -> IDLE on the next edge, no done, no extra beats, and the start pulses have no effect.
